// File: rtl/fpu_bus_sequencer.sv
// Serialises one (A, B, opcode) request into FPU 8-bit register-bus cycles and returns the result.
// Optional WAIT_END timeout abort is enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_bus_sequencer #(
   parameter int STROBE_CYC  = 1,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [7:0]  req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_err,
   output logic [3:0]  fpu_addr,
   output logic [7:0]  fpu_wdata,
   input  logic [7:0]  fpu_rdata,
   output logic        fpu_cs_n,
   output logic        fpu_rd_n,
   output logic        fpu_wr_n,
   output logic        fpu_end_ack,
   input  logic        fpu_cmd_end,
   input  logic        fpu_busy
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_A     = 4'd1;
   localparam logic [3:0] S_WR_B     = 4'd2;
   localparam logic [3:0] S_WR_OP    = 4'd3;
   localparam logic [3:0] S_START    = 4'd4;
   localparam logic [3:0] S_WAIT_END = 4'd5;
   localparam logic [3:0] S_RD_RES   = 4'd6;
   localparam logic [3:0] S_ACK      = 4'd7;
   localparam logic [3:0] S_RSP      = 4'd8;

   // PH_GAP is the cs_n-high cycle that separates consecutive access groups.
   localparam logic [1:0] PH_SETUP  = 2'd0;
   localparam logic [1:0] PH_STROBE = 2'd1;
   localparam logic [1:0] PH_HOLD   = 2'd2;
   localparam logic [1:0] PH_GAP    = 2'd3;

   localparam int             SW        = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
   localparam logic [SW-1:0]  SCNT_LAST = SW'(STROBE_CYC - 1);

   logic [3:0]    r_state;
   logic [1:0]    r_phase;
   logic [1:0]    r_idx;
   logic [SW-1:0] r_scnt;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [7:0]    r_op;
   logic [31:0]   r_result;

   logic       w_group;
   logic       w_quad;
   logic       w_active;
   logic [3:0] w_next;
   logic [3:0] w_addr;
   logic [7:0] w_wdata;
   logic [1:0] w_last_idx;

   always_comb begin
      w_group = 1'b0;
      w_quad  = 1'b0;
      w_next  = S_IDLE;
      w_addr  = 4'd0;
      w_wdata = 8'h00;
      case (r_state)
         S_WR_A: begin
            w_group = 1'b1;
            w_quad  = 1'b1;
            w_next  = S_WR_B;
            w_addr  = {2'b00, r_idx};
            w_wdata = r_a[{r_idx, 3'b000} +: 8];
         end
         S_WR_B: begin
            w_group = 1'b1;
            w_quad  = 1'b1;
            w_next  = S_WR_OP;
            w_addr  = 4'd4 + {2'b00, r_idx};
            w_wdata = r_b[{r_idx, 3'b000} +: 8];
         end
         S_WR_OP: begin
            w_group = 1'b1;
            w_next  = S_START;
            w_addr  = 4'd8;
            w_wdata = r_op;
         end
         S_START: begin
            w_group = 1'b1;
            w_next  = S_WAIT_END;
            w_addr  = 4'd9;
         end
         S_RD_RES: begin
            w_group = 1'b1;
            w_quad  = 1'b1;
            w_next  = S_ACK;
            w_addr  = 4'd9 + {2'b00, r_idx};
         end
         default: ;
      endcase
   end

   assign w_active   = w_group && (r_phase != PH_GAP);
   assign w_last_idx = w_quad ? 2'd3 : 2'd0;

   assign fpu_addr    = w_active ? w_addr : 4'd0;
   assign fpu_wdata   = w_active ? w_wdata : 8'h00;
   assign fpu_cs_n    = ~w_active;
   assign fpu_wr_n    = ~(w_active && (r_phase == PH_STROBE) && (r_state != S_RD_RES));
   assign fpu_rd_n    = ~(w_active && (r_phase == PH_STROBE) && (r_state == S_RD_RES));
   assign fpu_end_ack = (r_state == S_ACK);
   assign rsp_valid   = (r_state == S_RSP);
   assign rsp_result  = r_result;
   assign req_ready   = (r_state == S_IDLE) && !fpu_busy;

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic          r_err;
   logic [TW-1:0] r_tcnt;
   assign rsp_err = r_err;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state  <= S_IDLE;
         r_phase  <= PH_SETUP;
         r_idx    <= 2'd0;
         r_scnt   <= '0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_op     <= 8'd0;
         r_result <= 32'd0;
`ifdef FPU_SEQ_TIMEOUT_EN
         r_err    <= 1'b0;
         r_tcnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  r_a     <= req_a;
                  r_b     <= req_b;
                  r_op    <= req_op;
                  r_idx   <= 2'd0;
                  r_phase <= PH_SETUP;
                  r_state <= S_WR_A;
`ifdef FPU_SEQ_TIMEOUT_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            S_WR_A, S_WR_B, S_WR_OP, S_START, S_RD_RES: begin
               case (r_phase)
                  PH_GAP:   r_phase <= PH_SETUP;
                  PH_SETUP: begin
                     r_phase <= PH_STROBE;
                     r_scnt  <= '0;
                  end
                  PH_STROBE: begin
                     if (r_scnt == SCNT_LAST) begin
                        r_phase <= PH_HOLD;
                        if (r_state == S_RD_RES)
                           r_result[{r_idx, 3'b000} +: 8] <= fpu_rdata;
                     end else begin
                        r_scnt <= r_scnt + 1'b1;
                     end
                  end
                  default: begin
                     if (r_idx == w_last_idx) begin
                        r_idx   <= 2'd0;
                        r_phase <= PH_GAP;
                        r_state <= w_next;
`ifdef FPU_SEQ_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                     end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_phase <= PH_SETUP;
                     end
                  end
               endcase
            end
            S_WAIT_END: begin
               // cmd_end is a level: an already-high flag is consumed on the first cycle here.
               if (fpu_cmd_end) begin
                  r_state <= S_RD_RES;
                  r_phase <= PH_SETUP;
`ifdef FPU_SEQ_TIMEOUT_EN
               end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
                  r_state  <= S_RSP;
                  r_result <= 32'h7FC0_0000;
                  r_err    <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
`endif
               end
            end
            S_ACK: begin
               if (!fpu_cmd_end)
                  r_state <= S_RSP;
            end
            S_RSP: begin
               if (rsp_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_bus_sequencer.sv
// Self-checking bench for fpu_bus_sequencer: behavioural FPU register-bus model plus a result scoreboard.
module tb_fpu_bus_sequencer;

   localparam logic [7:0] OP_MUL = 8'h02;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic [7:0]  req_op = 8'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_err;
   logic [3:0]  fpu_addr;
   logic [7:0]  fpu_wdata;
   logic [7:0]  fpu_rdata;
   logic        fpu_cs_n;
   logic        fpu_rd_n;
   logic        fpu_wr_n;
   logic        fpu_end_ack;
   logic        fpu_cmd_end;
   logic        fpu_busy;

   always #5 clk = ~clk;

   fpu_bus_sequencer #(.STROBE_CYC(1), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata),
      .fpu_cs_n(fpu_cs_n), .fpu_rd_n(fpu_rd_n), .fpu_wr_n(fpu_wr_n),
      .fpu_end_ack(fpu_end_ack), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
      if (op == OP_MUL && a == 32'h3FFFFFFF && b == 32'h40490FDA)
         return 32'h40C90FD9;
      return (a ^ {b[15:0], b[31:16]}) + {24'd0, op};
   endfunction

   // ---------------- FPU bus model ----------------
   logic [7:0]  m_regs [0:15];
   logic        m_started = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_cmd_end = 1'b0;
   logic        m_prev_wr = 1'b1;
   logic        m_prev_rd = 1'b1;
   logic [31:0] m_res = 32'd0;
   int          m_cnt = 0;
   int          m_since = 0;
   int          m_wait_act = 0;
   int          m_start_cyc = 0;
   int          model_lat = 4;
   logic        model_kill = 1'b0;
   logic        force_busy = 1'b0;
   logic [3:0]  wr_log_a[$];
   logic [7:0]  wr_log_d[$];
   logic [3:0]  rd_log_a[$];
   int          rk;

   assign fpu_busy    = m_busy | force_busy;
   assign fpu_cmd_end = m_cmd_end;

   always_comb begin
      fpu_rdata = 8'h00;
      rk = int'(fpu_addr) - 9;
      if (rk >= 0 && rk <= 3)
         fpu_rdata = m_res[8*rk +: 8];
   end

   always @(negedge clk) begin
      if (!arst_n) begin
         m_started <= 1'b0;
         m_busy    <= 1'b0;
         m_cmd_end <= 1'b0;
         m_prev_wr <= 1'b1;
         m_prev_rd <= 1'b1;
      end else begin
         m_prev_wr <= fpu_cs_n | fpu_wr_n;
         m_prev_rd <= fpu_cs_n | fpu_rd_n;
         if (m_started) begin
            m_since <= m_since + 1;
            if (m_since >= 1 && !fpu_cs_n)
               m_wait_act <= m_wait_act + 1;
            if (m_cnt == 0) begin
               m_cmd_end <= 1'b1;
               m_busy    <= 1'b0;
               m_started <= 1'b0;
            end else if (m_cnt > 0) begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (model_kill) begin
            m_started <= 1'b0;
            m_busy    <= 1'b0;
         end
         if (!fpu_cs_n && !fpu_wr_n && m_prev_wr) begin
            wr_log_a.push_back(fpu_addr);
            wr_log_d.push_back(fpu_wdata);
            m_regs[fpu_addr] <= fpu_wdata;
            if (fpu_addr == 4'd9) begin
               m_start_cyc <= cyc;
               m_since     <= 0;
               m_res <= model_fn({m_regs[3], m_regs[2], m_regs[1], m_regs[0]},
                                 {m_regs[7], m_regs[6], m_regs[5], m_regs[4]}, m_regs[8]);
               if (model_lat == 0) begin
                  m_cmd_end <= 1'b1;
               end else begin
                  m_started <= 1'b1;
                  m_busy    <= 1'b1;
                  m_cnt     <= model_lat;
               end
            end
         end
         if (!fpu_cs_n && !fpu_rd_n && m_prev_rd)
            rd_log_a.push_back(fpu_addr);
         if (fpu_end_ack && m_cmd_end)
            m_cmd_end <= 1'b0;
      end
   end

   // ---------------- drivers (no checking inside) ----------------
   task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                           output bit ok);
      ok = 1'b0;
      @(negedge clk);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (req_ready) begin
            exp_q.push_back(model_fn(a, b, op));
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(input int hold, output logic [31:0] res, output logic err, output bit ok);
      ok = 1'b0;
      res = 32'd0;
      err = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         #1;
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      repeat (hold) @(negedge clk);
      res = rsp_result;
      err = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      $display("rsp: result=%08h err=%0b", res, err);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      arst_n = 1'b0;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;
      #1;
      n_cmp++; if ({fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack} !== 4'b1110) begin n_bad++;
         $display("FAIL reset_strobes: got %b want 1110", {fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack}); end
      n_cmp++; if (fpu_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", fpu_addr); end
      n_cmp++; if (fpu_wdata !== 8'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", fpu_wdata); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_result !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_write_seq();
      logic [7:0] exp_d [0:9];
      logic [31:0] res, e;
      logic err;
      bit ok;
      int w0;
      exp_d = '{8'hFF, 8'hFF, 8'hFF, 8'h3F, 8'hDA, 8'h0F, 8'h49, 8'h40, OP_MUL, 8'h00};
      w0 = wr_log_a.size();
      model_lat = 5;
      send_req(32'h3FFFFFFF, 32'h40490FDA, OP_MUL, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_accept: got no accept want accept"); end
      get_rsp(0, res, err, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_rsp_timeout: got no rsp_valid want rsp_valid"); end
      n_cmp++; if (wr_log_a.size() - w0 != 10) begin n_bad++;
         $display("FAIL wr_count: got %0d want 10", wr_log_a.size() - w0); end
      for (int i = 0; i < 10 && w0 + i < wr_log_a.size(); i++) begin
         n_cmp++;
         if (wr_log_a[w0+i] !== 4'(i) || wr_log_d[w0+i] !== exp_d[i]) begin n_bad++;
            $display("FAIL wr_byte%0d: got addr %0d data %h want addr %0d data %h",
                     i, wr_log_a[w0+i], wr_log_d[w0+i], i, exp_d[i]); end
      end
      n_cmp++; if (m_start_cyc - acc_cyc != 31) begin n_bad++;
         $display("FAIL wr_start_timing: got start strobe %0d cycles after accept want 31",
                  m_start_cyc - acc_cyc); end
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL wr_result: got %h with empty scoreboard", res); end
      else begin
         e = exp_q.pop_front();
         if (res !== e) begin n_bad++; $display("FAIL wr_result: got %h want %h", res, e); end
      end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", err); end
   endtask

   task automatic test_wait_latency();
      logic [31:0] res, e;
      logic err;
      bit ok;
      int wa0, r0;
      wa0 = m_wait_act;
      r0 = rd_log_a.size();
      model_lat = 200;
      send_req(32'h3FFFFFFF, 32'h40490FDA, OP_MUL, ok);
      get_rsp(0, res, err, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL lat_rsp_timeout: got no rsp_valid want rsp_valid"); end
      n_cmp++; if (m_wait_act != wa0) begin n_bad++;
         $display("FAIL lat_bus_idle: got %0d busy-bus cycles during wait want 0", m_wait_act - wa0); end
      n_cmp++; if (rd_log_a.size() - r0 != 4) begin n_bad++;
         $display("FAIL lat_rd_count: got %0d want 4", rd_log_a.size() - r0); end
      for (int i = 0; i < 4 && r0 + i < rd_log_a.size(); i++) begin
         n_cmp++; if (rd_log_a[r0+i] !== 4'(9 + i)) begin n_bad++;
            $display("FAIL lat_rd_addr%0d: got %0d want %0d", i, rd_log_a[r0+i], 9 + i); end
      end
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL lat_result: got %h with empty scoreboard", res); end
      else begin
         e = exp_q.pop_front();
         if (res !== e) begin n_bad++; $display("FAIL lat_result: got %h want %h", res, e); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] res, e;
      bit ok, seen;
      model_lat = 3;
      send_req(32'h12345678, 32'h9ABCDEF0, 8'h05, ok);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk); #1;
         if (rsp_valid) begin seen = 1'b1; break; end
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
      e = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
      req_a = 32'h1; req_b = 32'h2; req_op = 8'h03; req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== e || req_ready !== 1'b0) begin n_bad++;
            $display("FAIL bp_hold%0d: got valid %b result %h ready %b want 1 %h 0",
                     i, rsp_valid, rsp_result, req_ready, e); end
         @(negedge clk); #1;
      end
      req_valid = 1'b0;
      res = rsp_result;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      $display("rsp: result=%08h err=%0b", res, rsp_err);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid %b want 0", rsp_valid); end
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_result: got %h with empty scoreboard", res); end
      else begin
         e = exp_q.pop_front();
         if (res !== e) begin n_bad++; $display("FAIL bp_result: got %h want %h", res, e); end
      end
   endtask

   task automatic test_busy_stall();
      logic [31:0] res, e;
      logic err;
      bit ok;
      model_lat = 2;
      force_busy = 1'b1;
      @(negedge clk);
      req_a = 32'hCAFEF00D; req_b = 32'h0BADC0DE; req_op = 8'h11; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (req_ready !== 1'b0) begin n_bad++;
            $display("FAIL busy_stall%0d: got ready %b want 0", i, req_ready); end
         @(negedge clk);
      end
      force_busy = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL busy_release: got ready %b want 1", req_ready); end
      exp_q.push_back(model_fn(32'hCAFEF00D, 32'h0BADC0DE, 8'h11));
      @(posedge clk); #1;
      req_valid = 1'b0;
      get_rsp(1, res, err, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL busy_result: got no response want one"); end
      else begin
         e = exp_q.pop_front();
         if (res !== e) begin n_bad++; $display("FAIL busy_result: got %h want %h", res, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, res, e;
      logic [7:0] op;
      logic err;
      bit ok;
      for (int t = 0; t < 5; t++) begin
         a = $urandom; b = $urandom; op = 8'($urandom_range(0, 255));
         model_lat = (t == 0) ? 0 : $urandom_range(0, 20);
         send_req(a, b, op, ok);
         get_rsp($urandom_range(0, 3), res, err, ok);
         n_cmp++;
         if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL b2b%0d_result: got no response want one", t); end
         else begin
            e = exp_q.pop_front();
            if (res !== e || err !== 1'b0) begin n_bad++;
               $display("FAIL b2b%0d_result: got %h err %b want %h err 0", t, res, err, e); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, e;
      logic err;
      bit ok, hit;
      int w0, r0;
      model_lat = 1000;
      send_req(32'h0F0F0F0F, 32'hF0F0F0F0, 8'h07, ok);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (m_started && m_since >= 4) begin hit = 1'b1; break; end
      end
      n_cmp++; if (!hit) begin n_bad++; $display("FAIL rst_mid_reach_wait: got no wait phase want wait phase"); end
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      n_cmp++; if ({fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack, rsp_valid} !== 5'b11100) begin n_bad++;
         $display("FAIL rst_mid_outputs: got %b want 11100",
                  {fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack, rsp_valid}); end
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      exp_q.delete();
      w0 = wr_log_a.size();
      r0 = rd_log_a.size();
      repeat (30) @(negedge clk);
      n_cmp++; if (wr_log_a.size() != w0 || rd_log_a.size() != r0) begin n_bad++;
         $display("FAIL rst_mid_quiet: got %0d writes %0d reads want 0 0",
                  wr_log_a.size() - w0, rd_log_a.size() - r0); end
      model_lat = 4;
      send_req(32'h40000000, 32'h3F800000, OP_MUL, ok);
      get_rsp(0, res, err, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL rst_mid_fresh: got no response want one"); end
      else begin
         e = exp_q.pop_front();
         if (res !== e) begin n_bad++; $display("FAIL rst_mid_fresh: got %h want %h", res, e); end
      end
   endtask

`ifdef FPU_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] res, e;
      logic err;
      bit ok;
      int r0;
      r0 = rd_log_a.size();
      model_lat = -1;
      send_req(32'h11111111, 32'h22222222, 8'h01, ok);
      get_rsp(0, res, err, ok);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_cmp++; if (!ok || res !== 32'h7FC00000 || err !== 1'b1) begin n_bad++;
         $display("FAIL timeout_rsp: got %h err %b want 7fc00000 err 1", res, err); end
      n_cmp++; if (rd_log_a.size() != r0) begin n_bad++;
         $display("FAIL timeout_no_reads: got %0d reads want 0", rd_log_a.size() - r0); end
      @(negedge clk); model_kill = 1'b1;
      @(negedge clk); model_kill = 1'b0;
      model_lat = 3;
      send_req(32'h33333333, 32'h44444444, 8'h09, ok);
      get_rsp(0, res, err, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin n_bad++; $display("FAIL timeout_recover: got no response want one"); end
      else begin
         e = exp_q.pop_front();
         if (res !== e || err !== 1'b0) begin n_bad++;
            $display("FAIL timeout_recover: got %h err %b want %h err 0", res, err, e); end
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_seq();
      test_wait_latency();
      test_backpressure();
      test_busy_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef FPU_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
